multi_phase_clock_generator: RTL and testbench

Programmable multi-channel clock generator that derives NUM_CHANNELS phase-related output clocks from `clk_in`, all sharing one programmable period. Each channel has its own rise and fall position within the period, which enables non-overlapping clocks, duty-cycle control and phase offsets. Configuration enters through a valid/ready handshake. A new configuration is applied atomically at a period boundary, so no glitches or truncated phases occur. It is the parametrised successor of the single-channel high/low-phase clock divider and feeds clock-gated and multi-phase datapaths.

---
 rtl/multi_phase_clock_generator.sv | 82 ++++++++
 tb/tb_multi_phase_clock_generator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multi_phase_clock_generator.sv
// multi_phase_clock_generator: N phase-related clocks with shared programmable period and glitch-free reconfiguration
module multi_phase_clock_generator #(
  parameter int CYCLE_WIDTH  = 16,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                                 clk_in,
  input  logic                                 arst,
  input  logic                                 enable,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [CYCLE_WIDTH-1:0]               cfg_period,
  input  logic [NUM_CHANNELS*CYCLE_WIDTH-1:0]  cfg_rise,
  input  logic [NUM_CHANNELS*CYCLE_WIDTH-1:0]  cfg_fall,
  output logic [NUM_CHANNELS-1:0]              clk_out,
  output logic                                 sync_out
);
  localparam int W = CYCLE_WIDTH;
  localparam int N = NUM_CHANNELS;
  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0]   phase_q, phase_d, per_q, pper_q, peff;
  logic [N*W-1:0] rise_q, fall_q, prise_q, pfall_q;
  logic           pend_q, pend_d, sync_q, sync_d, wrap, accept, apply;
  logic [N-1:0]   clk_q, clk_d;

  assign cfg_ready = !pend_q;
  assign clk_out   = clk_q;
  assign sync_out  = sync_q;

  // Period sequencing, handshake acceptance and wrap-aligned apply decisions
  always_comb begin
    peff    = (per_q == '0) ? ONE : per_q;
    wrap    = phase_q >= peff - ONE;
    phase_d = (enable && !wrap) ? phase_q + ONE : '0;
    sync_d  = enable && (phase_d == '0);
    accept  = cfg_valid && !pend_q;
    apply   = pend_q && (wrap || !enable);
    pend_d  = accept || (pend_q && !apply);
  end

  // A position outside the period never fires, so such a channel just holds its level
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [W-1:0] r, f;
    logic         rise_hit, fall_hit;
    assign r        = rise_q[i*W +: W];
    assign f        = fall_q[i*W +: W];
    assign rise_hit = (phase_q == r) && (r < peff);
    assign fall_hit = (phase_q == f) && (f < peff);
    assign clk_d[i] = enable && (r != f) && (rise_hit || (clk_q[i] && !fall_hit));
  end

  // State update; pending config is copied to active only at apply, keeping each period whole
  always_ff @(posedge clk_in or posedge arst) begin
    if (arst) begin
      phase_q <= '0;
      per_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pper_q  <= '0;
      prise_q <= '0;
      pfall_q <= '0;
      pend_q  <= 1'b0;
      clk_q   <= '0;
      sync_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      sync_q  <= sync_d;
      if (accept) begin
        pper_q  <= cfg_period;
        prise_q <= cfg_rise;
        pfall_q <= cfg_fall;
      end
      if (apply) begin
        per_q  <= pper_q;
        rise_q <= prise_q;
        fall_q <= pfall_q;
      end
    end
  end
endmodule

// File: tb/tb_multi_phase_clock_generator.sv
// tb_multi_phase_clock_generator: table plus hand sequences, expectations queued at drive time and checked after each edge
module tb_multi_phase_clock_generator;
  typedef struct packed {
    logic [15:0] per;
    logic [63:0] rise;
    logic [63:0] fall;
  } cfg_t;
  typedef struct packed {
    logic       en;
    logic       v;
    cfg_t       cfg;
    logic [3:0] clk;
    logic       sync;
    logic       rdy;
  } vec_t;
  typedef struct packed {
    logic [3:0]  clk;
    logic        sync;
    logic        rdy;
    logic [31:0] id;
  } exp_t;

  logic        clk_in = 0, arst = 1, enable = 0, cfg_valid = 0;
  logic        cfg_ready, sync_out;
  logic [15:0] cfg_period = 0;
  logic [63:0] cfg_rise = 0, cfg_fall = 0;
  logic [3:0]  clk_out;

  int   n_chk = 0, n_pass = 0, id = 0;
  exp_t q[$];
  exp_t e;
  vec_t tbl[14];
  cfg_t cz, ca, cb, cd;

  multi_phase_clock_generator #(.CYCLE_WIDTH(16), .NUM_CHANNELS(4)) dut (
    .clk_in(clk_in), .arst(arst), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_period(cfg_period), .cfg_rise(cfg_rise),
    .cfg_fall(cfg_fall), .clk_out(clk_out), .sync_out(sync_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic cfg_t mk(input logic [15:0] p,
                              input logic [15:0] r0, r1, r2, r3,
                              input logic [15:0] f0, f1, f2, f3);
    mk.per  = p;
    mk.rise = {r3, r2, r1, r0};
    mk.fall = {f3, f2, f1, f0};
  endfunction

  task automatic chk(input string name, input int tag, input logic [3:0] got, input logic [3:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, tag, got, want);
  endtask

  task automatic cyc(input logic en, input logic v, input cfg_t c,
                     input logic [3:0] xclk, input logic xsync, input logic xrdy);
    exp_t x;
    @(negedge clk_in);
    enable     = en;
    cfg_valid  = v;
    cfg_period = c.per;
    cfg_rise   = c.rise;
    cfg_fall   = c.fall;
    x.clk = xclk; x.sync = xsync; x.rdy = xrdy; x.id = id;
    id++;
    q.push_back(x);
  endtask

  task automatic drain;
    int budget = 5;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk_in);
      #2;
      budget--;
    end
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", q.size());
  endtask

  always @(posedge clk_in) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("clk_out", e.id, clk_out, e.clk);
      chk("sync_out", e.id, {3'b0, sync_out}, {3'b0, e.sync});
      chk("cfg_ready", e.id, {3'b0, cfg_ready}, {3'b0, e.rdy});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    cz = '0;
    ca = mk(16'd4, 16'd0, 16'd1, 16'd1, 16'd0, 16'd2, 16'd3, 16'd1, 16'd9);
    cb = mk(16'd6, 16'd0, 16'd3, 16'd1, 16'd0, 16'd3, 16'd0, 16'd1, 16'd9);
    cd = mk(16'd5, 16'd0, 16'd2, 16'd3, 16'd4, 16'd1, 16'd4, 16'd3, 16'd0);
    tbl[0]  = '{1'b1, 1'b0, cz, 4'h0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, cz, 4'h0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, cz, 4'h0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, cz, 4'h0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, ca, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, cz, 4'h0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, cz, 4'h9, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, cz, 4'hB, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, cz, 4'hA, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, cz, 4'h8, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, cz, 4'h9, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, cz, 4'hB, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, cz, 4'hA, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, cz, 4'h8, 1'b1, 1'b1};

    repeat (2) @(negedge clk_in);
    chk("reset_clk", 0, clk_out, 4'h0);
    chk("reset_sync", 0, {3'b0, sync_out}, 4'h0);
    chk("reset_rdy", 0, {3'b0, cfg_ready}, 4'h1);
    arst = 0;

    foreach (tbl[i]) cyc(tbl[i].en, tbl[i].v, tbl[i].cfg, tbl[i].clk, tbl[i].sync, tbl[i].rdy);

    cyc(1, 0, cz, 4'h9, 0, 1);
    cyc(1, 1, cb, 4'hB, 0, 0);
    cyc(1, 0, cz, 4'hA, 0, 0);
    cyc(1, 0, cz, 4'h8, 1, 1);
    cyc(1, 0, cz, 4'h9, 0, 1);
    cyc(1, 0, cz, 4'h9, 0, 1);
    cyc(1, 0, cz, 4'h9, 0, 1);
    cyc(1, 0, cz, 4'hA, 0, 1);
    cyc(1, 0, cz, 4'hA, 0, 1);
    cyc(1, 0, cz, 4'hA, 1, 1);
    cyc(1, 0, cz, 4'h9, 0, 1);
    cyc(1, 0, cz, 4'h9, 0, 1);

    cyc(0, 0, cz, 4'h0, 0, 1);
    cyc(1, 0, cz, 4'h9, 0, 1);
    cyc(1, 0, cz, 4'h9, 0, 1);
    cyc(1, 0, cz, 4'h9, 0, 1);
    cyc(1, 0, cz, 4'hA, 0, 1);
    cyc(1, 0, cz, 4'hA, 0, 1);
    cyc(1, 0, cz, 4'hA, 1, 1);

    cyc(1, 1, ca, 4'h9, 0, 0);
    cyc(1, 1, cd, 4'h9, 0, 0);
    cyc(1, 1, cd, 4'h9, 0, 0);
    cyc(1, 1, cd, 4'hA, 0, 0);
    cyc(1, 1, cd, 4'hA, 0, 0);
    cyc(1, 1, cd, 4'hA, 1, 1);
    cyc(1, 1, cd, 4'hB, 0, 0);
    cyc(1, 0, cz, 4'hB, 0, 0);
    cyc(1, 0, cz, 4'hA, 0, 0);
    cyc(1, 0, cz, 4'h8, 1, 1);
    cyc(1, 0, cz, 4'h1, 0, 1);
    cyc(1, 0, cz, 4'h0, 0, 1);
    cyc(1, 0, cz, 4'h2, 0, 1);
    cyc(1, 0, cz, 4'h2, 0, 1);
    cyc(1, 0, cz, 4'h8, 1, 1);
    cyc(1, 1, ca, 4'h1, 0, 0);
    cyc(1, 0, cz, 4'h0, 0, 0);
    drain();

    @(negedge clk_in);
    chk("pre_arst_rdy", 1, {3'b0, cfg_ready}, 4'h0);
    #2 arst = 1;
    #1;
    chk("arst_clk", 1, clk_out, 4'h0);
    chk("arst_sync", 1, {3'b0, sync_out}, 4'h0);
    chk("arst_rdy", 1, {3'b0, cfg_ready}, 4'h1);
    @(negedge clk_in);
    arst = 0;
    repeat (4) cyc(1, 0, cz, 4'h0, 1, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
